// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing the single ddr_sdram user command port among
// NUM_REQ requesters. The winning request is latched into registered command
// outputs; WRITE/READ is held until the controller raises BUSY, and the next
// grant waits until BUSY has fallen again.
module ddr_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BURST_LENGTH = 16
) (
    input  logic                               SYS_CLK_100M,
    input  logic                               RST_N,
    input  logic [NUM_REQ-1:0]                 REQ_VALID,
    input  logic [NUM_REQ-1:0]                 REQ_WR,
    input  logic [2*NUM_REQ-1:0]               REQ_BA,
    input  logic [13*NUM_REQ-1:0]              REQ_ROW,
    input  logic [10*NUM_REQ-1:0]              REQ_COL,
    input  logic [4*NUM_REQ-1:0]               REQ_LEN,
    input  logic [16*BURST_LENGTH*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]                 REQ_ACK,
    output logic [NUM_REQ-1:0]                 REQ_DONE,
    output logic [2:0]                         GRANT_ID,
    output logic [1:0]                         BA_IN,
    output logic [12:0]                        ADDR_ROW_IN,
    output logic [9:0]                         ADDR_COL_IN,
    output logic [3:0]                         WRITE_LENGTH,
    output logic [16*BURST_LENGTH-1:0]         DATA_IN,
    output logic                               WRITE,
    output logic                               READ,
    input  logic                               BUSY
);

    localparam int DW    = 16 * BURST_LENGTH;
    // Requesters are unpacked into 8 slots so a 3-bit index addresses them
    // exactly; slots beyond NUM_REQ are tied off and never win.
    localparam int SLOTS = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t             state;
    logic [2:0]         ptr;

    logic [SLOTS-1:0]   valid_slot;
    logic [SLOTS-1:0]   wr_slot;
    logic [1:0]         ba_slot   [SLOTS];
    logic [12:0]        row_slot  [SLOTS];
    logic [9:0]         col_slot  [SLOTS];
    logic [3:0]         len_slot  [SLOTS];
    logic [DW-1:0]      data_slot [SLOTS];

    logic [2:0]         win;
    logic               found;
    logic [2:0]         ptr_after_win;
    logic [NUM_REQ-1:0] ack_vec;
    logic [NUM_REQ-1:0] done_vec;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign valid_slot[gi] = REQ_VALID[gi];
                assign wr_slot[gi]    = REQ_WR[gi];
                assign ba_slot[gi]    = REQ_BA[2*gi +: 2];
                assign row_slot[gi]   = REQ_ROW[13*gi +: 13];
                assign col_slot[gi]   = REQ_COL[10*gi +: 10];
                assign len_slot[gi]   = REQ_LEN[4*gi +: 4];
                assign data_slot[gi]  = REQ_DATA[DW*gi +: DW];
            end else begin : g_pad
                assign valid_slot[gi] = 1'b0;
                assign wr_slot[gi]    = 1'b0;
                assign ba_slot[gi]    = '0;
                assign row_slot[gi]   = '0;
                assign col_slot[gi]   = '0;
                assign len_slot[gi]   = '0;
                assign data_slot[gi]  = '0;
            end
        end
    endgenerate

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [3:0] sum;
            logic [2:0] cand;
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NUM_REQ)) begin
                sum = sum - 4'(NUM_REQ);
            end
            cand = sum[2:0];
            if (!found && valid_slot[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Pointer advance past the winner and one-hot ack/done pulse vectors.
    always_comb begin
        ptr_after_win = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
        ack_vec       = '0;
        done_vec      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_vec[i]  = (3'(i) == win);
            done_vec[i] = (3'(i) == GRANT_ID);
        end
    end

    // Grant/issue/completion sequencer with all outputs registered.
    always_ff @(posedge SYS_CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            ptr          <= '0;
            REQ_ACK      <= '0;
            REQ_DONE     <= '0;
            GRANT_ID     <= '0;
            BA_IN        <= '0;
            ADDR_ROW_IN  <= '0;
            ADDR_COL_IN  <= '0;
            WRITE_LENGTH <= '0;
            DATA_IN      <= '0;
            WRITE        <= 1'b0;
            READ         <= 1'b0;
        end else begin
            REQ_ACK  <= '0;
            REQ_DONE <= '0;
            case (state)
                IDLE: begin
                    // No grant while the controller is busy (e.g. still initialising).
                    if (!BUSY && found) begin
                        BA_IN        <= ba_slot[win];
                        ADDR_ROW_IN  <= row_slot[win];
                        ADDR_COL_IN  <= col_slot[win];
                        WRITE_LENGTH <= len_slot[win];
                        DATA_IN      <= data_slot[win];
                        GRANT_ID     <= win;
                        ptr          <= ptr_after_win;
                        WRITE        <= wr_slot[win];
                        READ         <= ~wr_slot[win];
                        REQ_ACK      <= ack_vec;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Controller accepted the command once it reports busy.
                    if (BUSY) begin
                        WRITE <= 1'b0;
                        READ  <= 1'b0;
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!BUSY) begin
                        REQ_DONE <= done_vec;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
